filter_bank_sequencer: RTL and testbench

- Frame-level controller between the FFT power-spectrum stream and the 40-band filter bank.
- Selects a window of bins per FFT frame and feeds exactly FEED_LEN samples, zero-padding if needed, so the bank's rotating coefficient table stays frame-aligned.
- Captures the 40 band results and replays them downstream as an indexed serial stream for the LED mapper.
- Counts dropped and short frames.

---
 rtl/filter_bank_sequencer_if.sv | 37 +++
 rtl/filter_bank_sequencer.sv | 178 +++++++++++++++++
 tb/tb_filter_bank_sequencer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/filter_bank_sequencer_if.sv
// Handshake bundle between the FFT spectrum source, the filter bank and the band consumer.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface filter_bank_sequencer_if #(
    parameter int BIN_W     = 10,
    parameter int NUM_BANDS = 40
);
    logic [31:0]             spec_data;
    logic [BIN_W-1:0]        spec_index;
    logic                    spec_last;
    logic                    spec_valid;
    logic                    spec_ready;
    logic [31:0]             fb_in;
    logic                    fb_s_valid;
    logic                    fb_s_ready;
    logic [16*NUM_BANDS-1:0] fb_out;
    logic                    fb_m_valid;
    logic                    fb_m_ready;
    logic [15:0]             band_data;
    logic [5:0]              band_index;
    logic                    band_last;
    logic                    band_valid;
    logic                    band_ready;

    modport slave (
        input  spec_data, spec_index, spec_last, spec_valid, fb_s_ready,
        input  fb_out, fb_m_valid, band_ready,
        output spec_ready, fb_in, fb_s_valid, fb_m_ready,
        output band_data, band_index, band_last, band_valid
    );

    modport master (
        output spec_data, spec_index, spec_last, spec_valid, fb_s_ready,
        output fb_out, fb_m_valid, band_ready,
        input  spec_ready, fb_in, fb_s_valid, fb_m_ready,
        input  band_data, band_index, band_last, band_valid
    );
endinterface

// File: rtl/filter_bank_sequencer.sv
// Frame controller: feeds exactly FEED_LEN bins per FFT frame to the filter bank (zero-padding
// short frames), captures the band results and replays them as an indexed serial stream.
module filter_bank_sequencer #(
    parameter int START_BIN = 1,
    parameter int FEED_LEN  = 256,
    parameter int NUM_BANDS = 40,
    parameter int BIN_W     = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    filter_bank_sequencer_if.slave bus,
    output logic [15:0]            drop_count,
    output logic [15:0]            short_count
);
    localparam int              FC_W      = $clog2(FEED_LEN + 1);
    localparam logic [FC_W-1:0] FEED_LAST = FC_W'(FEED_LEN - 1);
    localparam logic [FC_W-1:0] CNT_ONE   = FC_W'(1);
    localparam logic [5:0]      BAND_LAST = 6'(NUM_BANDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SKIP  = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_PAD   = 3'd4,
        ST_WAIT  = 3'd5,
        ST_OUT   = 3'd6
    } state_t;

    state_t          state_r;
    logic [FC_W-1:0] feed_cnt_r;
    logic            mid_frame_r;
    logic [15:0]     capture_r [NUM_BANDS];
    logic            spec_xfer_s;
    logic            fb_xfer_s;
    logic            band_xfer_s;
    logic            mid_nxt_s;
    logic [5:0]      band_nxt_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Zero-latency feed path; held quiet while reset is asserted.
    always_comb begin
        bus.spec_ready = 1'b0;
        bus.fb_in      = 32'd0;
        bus.fb_s_valid = 1'b0;
        if (!reset) begin
            bus.spec_ready = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DRAIN, ST_OUT: bus.spec_ready = 1'b1;
                // The first in-window bin is left on the bus so FEED consumes it.
                ST_SKIP: bus.spec_ready = (bus.spec_index < BIN_W'(START_BIN));
                ST_FEED: begin
                    bus.fb_in      = bus.spec_data;
                    bus.fb_s_valid = bus.spec_valid;
                    bus.spec_ready = bus.fb_s_ready;
                end
                ST_PAD:  bus.fb_s_valid = 1'b1;
                default: bus.spec_ready = 1'b0;
            endcase
        end
    end

    // Transfer qualifiers and next-value helpers for the sequencer.
    always_comb begin
        spec_xfer_s = bus.spec_valid & bus.spec_ready;
        fb_xfer_s   = bus.fb_s_valid & bus.fb_s_ready;
        band_xfer_s = bus.band_valid & bus.band_ready;
        band_nxt_s  = bus.band_index + 6'd1;
        if (spec_xfer_s) begin
            mid_nxt_s = ~bus.spec_last;
        end else begin
            mid_nxt_s = mid_frame_r;
        end
    end

    // Frame sequencer with registered band stream, capture array and counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r         <= ST_IDLE;
            feed_cnt_r      <= '0;
            mid_frame_r     <= 1'b0;
            drop_count      <= 16'd0;
            short_count     <= 16'd0;
            bus.fb_m_ready  <= 1'b0;
            bus.band_data   <= 16'd0;
            bus.band_index  <= 6'd0;
            bus.band_last   <= 1'b0;
            bus.band_valid  <= 1'b0;
            for (int k = 0; k < NUM_BANDS; k++) begin
                capture_r[k] <= 16'd0;
            end
        end else begin
            bus.fb_m_ready <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (spec_xfer_s && bus.spec_last) begin
                        state_r <= ST_SKIP;
                    end
                end
                ST_SKIP: begin
                    if (spec_xfer_s && bus.spec_last) begin
                        short_count <= sat_inc(short_count);
                        feed_cnt_r  <= '0;
                        state_r     <= ST_PAD;
                    end else if (bus.spec_valid && !bus.spec_ready) begin
                        feed_cnt_r <= '0;
                        state_r    <= ST_FEED;
                    end
                end
                ST_FEED: begin
                    if (fb_xfer_s) begin
                        feed_cnt_r <= feed_cnt_r + CNT_ONE;
                        if (feed_cnt_r == FEED_LAST) begin
                            state_r <= bus.spec_last ? ST_WAIT : ST_DRAIN;
                        end else if (bus.spec_last) begin
                            short_count <= sat_inc(short_count);
                            state_r     <= ST_PAD;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (spec_xfer_s && bus.spec_last) begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_PAD: begin
                    if (fb_xfer_s) begin
                        feed_cnt_r <= feed_cnt_r + CNT_ONE;
                        if (feed_cnt_r == FEED_LAST) begin
                            state_r <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus.fb_m_valid) begin
                        for (int k = 0; k < NUM_BANDS; k++) begin
                            capture_r[k] <= bus.fb_out[16*k +: 16];
                        end
                        bus.fb_m_ready <= 1'b1;
                        bus.band_data  <= bus.fb_out[15:0];
                        bus.band_index <= 6'd0;
                        bus.band_last  <= (BAND_LAST == 6'd0);
                        bus.band_valid <= 1'b1;
                        mid_frame_r    <= 1'b0;
                        state_r        <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    mid_frame_r <= mid_nxt_s;
                    if (spec_xfer_s && bus.spec_last) begin
                        drop_count <= sat_inc(drop_count);
                    end
                    if (band_xfer_s) begin
                        if (bus.band_last) begin
                            bus.band_valid <= 1'b0;
                            bus.band_index <= 6'd0;
                            bus.band_last  <= 1'b0;
                            bus.band_data  <= 16'd0;
                            feed_cnt_r     <= '0;
                            mid_frame_r    <= 1'b0;
                            // A frame that began during replay is skipped to its end.
                            state_r        <= mid_nxt_s ? ST_IDLE : ST_SKIP;
                        end else begin
                            bus.band_index <= band_nxt_s;
                            bus.band_data  <= capture_r[band_nxt_s];
                            bus.band_last  <= (band_nxt_s == BAND_LAST);
                        end
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_filter_bank_sequencer.sv
// Directed bench for filter_bank_sequencer: frame alignment, full/short frames, back-pressure,
// dropped frames during band replay and mid-frame reset.
module tb_filter_bank_sequencer;
    localparam int NB = 40;
    localparam int FL = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] drop_count;
    logic [15:0] short_count;

    filter_bank_sequencer_if #(.BIN_W(10), .NUM_BANDS(NB)) bus ();

    filter_bank_sequencer #(.START_BIN(1), .FEED_LEN(FL), .NUM_BANDS(NB), .BIN_W(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .drop_count  (drop_count),
        .short_count (short_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] fb_q [$];
    logic [22:0] band_q [$];
    int          mr_cnt = 0;
    int          rdy_bad = 0;
    bit          toggle_mode = 1'b0;
    bit          band_hold = 1'b0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Ready generators for the filter bank and the band consumer.
    initial begin
        int cyc;
        cyc = 0;
        bus.fb_s_ready = 1'b1;
        bus.band_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            bus.fb_s_ready = toggle_mode ? (cyc % 3 == 0) : 1'b1;
            bus.band_ready = !band_hold;
        end
    end

    // Mid-cycle observer of every transfer.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.fb_s_valid && bus.fb_s_ready) fb_q.push_back(bus.fb_in);
            if (bus.band_valid && bus.band_ready)
                band_q.push_back({bus.band_index, bus.band_last, bus.band_data});
            if (bus.fb_m_ready) mr_cnt++;
            if (toggle_mode && bus.fb_s_valid && (bus.spec_ready !== bus.fb_s_ready)) rdy_bad++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic send_bin(input int d, input int idx, input bit last);
        int n;
        n = 0;
        bus.spec_valid = 1'b1;
        bus.spec_data  = 32'(d);
        bus.spec_index = 10'(idx);
        bus.spec_last  = last;
        @(negedge clk);
        while (bus.spec_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("send_timeout", 1, 0);
        @(posedge clk);
        #1;
        bus.spec_valid = 1'b0;
        bus.spec_last  = 1'b0;
    endtask

    task automatic send_frame(input int first, input int last_idx);
        for (int i = first; i <= last_idx; i++) send_bin(i, i, i == last_idx);
    endtask

    task automatic start_capture(input int base, output int lat);
        int n;
        n = 0;
        for (int k = 0; k < NB; k++) bus.fb_out[16*k +: 16] = 16'(base + k);
        bus.fb_m_valid = 1'b1;
        @(negedge clk);
        while (bus.fb_m_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("mready_timeout", 1, 0);
        chk("first_band_valid", bus.band_valid, 1);
        chk("first_band_data", bus.band_data, 16'(base));
        lat = n;
        @(posedge clk);
        #1;
        bus.fb_m_valid = 1'b0;
    endtask

    task automatic finish_capture(input int b0);
        int n;
        n = 0;
        while (band_q.size() < b0 + NB && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("band_timeout", 1, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic int fb_bad(input int f0, input int nfed);
        int bad;
        bad = 0;
        for (int i = 0; i < FL; i++) begin
            if (f0 + i >= fb_q.size()) bad++;
            else if (fb_q[f0 + i] !== ((i < nfed) ? 32'(i + 1) : 32'd0)) bad++;
        end
        return bad;
    endfunction

    function automatic int band_bad(input int b0, input int base);
        int bad;
        logic [22:0] e;
        bad = 0;
        for (int k = 0; k < NB; k++) begin
            e = {6'(k), (k == NB - 1), 16'(base + k)};
            if (b0 + k >= band_q.size()) bad++;
            else if (band_q[b0 + k] !== e) bad++;
        end
        return bad;
    endfunction

    initial begin
        int f0, b0, m0, r0, lat;
        bus.spec_valid = 1'b0;
        bus.spec_data  = 32'd0;
        bus.spec_index = 10'd0;
        bus.spec_last  = 1'b0;
        bus.fb_m_valid = 1'b0;
        bus.fb_out     = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_spec_ready", bus.spec_ready, 0);
        chk("rst_fb_s_valid", bus.fb_s_valid, 0);
        chk("rst_band_valid", bus.band_valid, 0);
        chk("rst_band_index", bus.band_index, 0);
        chk("rst_fb_m_ready", bus.fb_m_ready, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_short", short_count, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("idle_spec_ready", bus.spec_ready, 1);
        @(posedge clk);
        #1;

        // Alignment frame, then a full 512-bin frame
        f0 = fb_q.size();
        send_frame(0, 511);
        chk("align_no_feed", fb_q.size() - f0, 0);
        f0 = fb_q.size();
        send_frame(0, 511);
        chk("full_count", fb_q.size() - f0, FL);
        chk("full_values", fb_bad(f0, FL), 0);
        b0 = band_q.size();
        m0 = mr_cnt;
        start_capture(1000, lat);
        chk("capture_latency", lat, 1);
        finish_capture(b0);
        chk("band_stream_1000", band_bad(b0, 1000), 0);
        chk("mready_one_cycle", mr_cnt - m0, 1);
        chk("drop_zero", drop_count, 0);

        // Short frame of 100 bins
        f0 = fb_q.size();
        send_frame(0, 99);
        b0 = band_q.size();
        start_capture(2000, lat);
        finish_capture(b0);
        chk("short_count_total", fb_q.size() - f0, FL);
        chk("short_values_pad", fb_bad(f0, 99), 0);
        chk("short_counter", short_count, 1);
        chk("band_stream_2000", band_bad(b0, 2000), 0);

        // Filter-bank back-pressure, ready 1 of 3 cycles
        toggle_mode = 1'b1;
        r0 = rdy_bad;
        f0 = fb_q.size();
        send_frame(0, 511);
        toggle_mode = 1'b0;
        chk("ready_mirror", rdy_bad - r0, 0);
        chk("toggle_count", fb_q.size() - f0, FL);
        chk("toggle_values", fb_bad(f0, FL), 0);
        b0 = band_q.size();
        start_capture(4000, lat);
        finish_capture(b0);

        // Band stream stalled while a whole frame arrives
        f0 = fb_q.size();
        send_frame(0, 511);
        band_hold = 1'b1;
        b0 = band_q.size();
        start_capture(3000, lat);
        send_frame(0, 44);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("hold_valid", bus.band_valid, 1);
        chk("hold_data", bus.band_data, 3000);
        chk("hold_index", bus.band_index, 0);
        chk("hold_last", bus.band_last, 0);
        chk("drop_one", drop_count, 1);
        @(posedge clk);
        #1;
        band_hold = 1'b0;
        finish_capture(b0);
        chk("band_stream_3000", band_bad(b0, 3000), 0);
        chk("dropped_not_fed", fb_q.size() - f0, FL);
        f0 = fb_q.size();
        send_frame(0, 511);
        chk("after_drop_count", fb_q.size() - f0, FL);
        chk("after_drop_values", fb_bad(f0, FL), 0);
        b0 = band_q.size();
        start_capture(5000, lat);
        finish_capture(b0);
        chk("drop_still_one", drop_count, 1);

        // Reset in the middle of FEED
        f0 = fb_q.size();
        for (int i = 0; i <= 120; i++) send_bin(i, i, 1'b0);
        chk("prereset_fed", fb_q.size() - f0, 120);
        reset = 1'b0;
        bus.spec_valid = 1'b1;
        bus.spec_data  = 32'd121;
        bus.spec_index = 10'd121;
        @(negedge clk);
        chk("inrst_spec_ready", bus.spec_ready, 0);
        chk("inrst_fb_s_valid", bus.fb_s_valid, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.spec_valid = 1'b0;
        @(negedge clk);
        chk("postrst_drop", drop_count, 0);
        chk("postrst_short", short_count, 0);
        chk("postrst_band_valid", bus.band_valid, 0);
        chk("postrst_fb_s_valid", bus.fb_s_valid, 0);
        @(posedge clk);
        #1;
        f0 = fb_q.size();
        send_frame(121, 511);
        chk("postrst_no_feed", fb_q.size() - f0, 0);
        f0 = fb_q.size();
        send_frame(0, 511);
        chk("resume_count", fb_q.size() - f0, FL);
        chk("resume_values", fb_bad(f0, FL), 0);
        b0 = band_q.size();
        start_capture(6000, lat);
        finish_capture(b0);
        chk("band_stream_6000", band_bad(b0, 6000), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
